// File: rtl/binary_mul_pkg.sv
// binary_mul_pkg: shared widths and per-stage register layout for the radix-2 signed multiplier.
package binary_mul_pkg;
    localparam int WIDTH   = 15;
    localparam int PWIDTH  = 2 * WIDTH - 1;
    localparam int LATENCY = WIDTH + 1;
    typedef struct packed {
        logic signed [WIDTH-1:0] a;
        logic [WIDTH-1:0]        b;
        logic [PWIDTH-1:0]       acc;
    } stage_t;
endpackage

// File: rtl/binary_mul_stage.sv
// binary_mul_stage: one combinational radix-2 step; the top bit carries weight -2^BIT, so it subtracts.
module binary_mul_stage
    import binary_mul_pkg::*;
#(
    parameter int BIT = 0
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic                    b_bit,
    input  logic [PWIDTH-1:0]       acc_in,
    output logic [PWIDTH-1:0]       acc_out
);
    logic [PWIDTH-1:0] pp;
    assign pp      = b_bit ? {{(PWIDTH-WIDTH){a[WIDTH-1]}}, a} << BIT : '0;
    assign acc_out = (BIT == WIDTH - 1) ? acc_in - pp : acc_in + pp;
endmodule

// File: rtl/binary_mul_15_1_bi.sv
// binary_mul_15_1_bi: fully pipelined signed 15x15 -> 29-bit multiplier, 16 enabled edges of latency.
// Defining BINARY_MUL_15_1_BI_VALID_EN adds in_valid/out_valid carried alongside the data.
module binary_mul_15_1_bi
    import binary_mul_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic signed [WIDTH-1:0]  A,
    input  logic signed [WIDTH-1:0]  B,
`ifdef BINARY_MUL_15_1_BI_VALID_EN
    input  logic                     in_valid,
    output logic                     out_valid,
`endif
    output logic signed [PWIDTH-1:0] P
);
    stage_t            s   [WIDTH];
    logic [PWIDTH-1:0] nxt [WIDTH];
    for (genvar i = 0; i < WIDTH; i++) begin : g_step
        binary_mul_stage #(.BIT(i)) u_step (
            .a       (s[i].a),
            .b_bit   (s[i].b[i]),
            .acc_in  (s[i].acc),
            .acc_out (nxt[i])
        );
    end
    // the rst_n port is active-high despite its name
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < WIDTH; k++) s[k] <= '0;
            P <= '0;
        end else if (en) begin
            s[0] <= '{a: A, b: B, acc: '0};
            for (int k = 1; k < WIDTH; k++) s[k] <= '{a: s[k-1].a, b: s[k-1].b, acc: nxt[k-1]};
            P <= nxt[WIDTH-1];
        end
    end
`ifdef BINARY_MUL_15_1_BI_VALID_EN
    logic [LATENCY-1:0] vld;
    always_ff @(posedge clk) begin
        if (rst_n) vld <= '0;
        else if (en) vld <= {vld[LATENCY-2:0], in_valid};
    end
    assign out_valid = vld[LATENCY-1];
`endif
endmodule

// File: tb/tb_binary_mul_15_1_bi.sv
// tb_binary_mul_15_1_bi: table vectors and random pairs through a 16-edge expectation queue.
module tb_binary_mul_15_1_bi;
    import binary_mul_pkg::*;
    logic clk = 0, rst_n = 1, en = 0;
    logic signed [WIDTH-1:0] A = '0, B = '0;
    logic [PWIDTH-1:0] P;
`ifdef BINARY_MUL_15_1_BI_VALID_EN
    logic in_valid = 0, out_valid;
`endif
    int checks = 0, errors = 0;
    typedef struct packed { logic [PWIDTH-1:0] p; logic v; } exp_t;
    typedef struct { int a; int b; logic [PWIDTH-1:0] want; } vec_t;
    exp_t q[$];
    exp_t cur;
    vec_t tbl[10];

    always #5 clk = ~clk;

    binary_mul_15_1_bi dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .A         (A),
        .B         (B),
`ifdef BINARY_MUL_15_1_BI_VALID_EN
        .in_valid  (in_valid),
        .out_valid (out_valid),
`endif
        .P         (P)
    );

    task automatic check(input string name, input logic [PWIDTH-1:0] got, input logic [PWIDTH-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic tick(input logic r, input logic e, input int a, input int b,
                        input logic [PWIDTH-1:0] want, input logic vin);
        A = WIDTH'(a);
        B = WIDTH'(b);
        en = e;
        rst_n = r;
`ifdef BINARY_MUL_15_1_BI_VALID_EN
        in_valid = vin;
`endif
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            repeat (LATENCY - 1) q.push_back('0);
            cur = '0;
        end else if (e) begin
            q.push_back('{p: want, v: vin});
            cur = q.pop_front();
        end
        check("P", P, cur.p);
`ifdef BINARY_MUL_15_1_BI_VALID_EN
        check("out_valid", PWIDTH'(out_valid), PWIDTH'(cur.v));
`endif
    endtask

    task automatic go(input int a, input int b, input logic [PWIDTH-1:0] want);
        tick(0, 1, a, b, want, 1);
    endtask

    initial begin
        tbl = '{
            '{5, 7, PWIDTH'(35)},
            '{3, -4, PWIDTH'(-12)},
            '{-3, -4, PWIDTH'(12)},
            '{-1, -1, PWIDTH'(1)},
            '{0, -16384, PWIDTH'(0)},
            '{-16384, -16384, 29'h1000_0000},
            '{16383, -16384, PWIDTH'(-268419072)},
            '{16383, 16383, PWIDTH'(268402689)},
            '{-16384, 1, PWIDTH'(-16384)},
            '{1, -16384, PWIDTH'(-16384)}
        };
        // reset held with en=1 and live operands must still give 0
        tick(1, 1, 5, 7, '0, 1);
        tick(1, 1, 5, 7, '0, 1);
        go(5, 7, PWIDTH'(35));
        repeat (15) go(0, 0, '0);
        foreach (tbl[i]) go(tbl[i].a, tbl[i].b, tbl[i].want);
        repeat (15) go(0, 0, '0);
        for (int i = 1; i <= 40; i++) go(i, -i, PWIDTH'(-i * i));
        for (int i = 1; i <= 30; i++) begin
            if (i == 12) repeat (5) tick(0, 0, 999, -999, '0, 1);
            go(i * 37, 100 - i, PWIDTH'(i * 37 * (100 - i)));
        end
        for (int i = 0; i < 8; i++) go(1000 + i, -7, PWIDTH'((1000 + i) * -7));
        tick(1, 0, 0, 0, '0, 0);
        for (int i = 1; i <= 20; i++) go(i + 200, 3, PWIDTH'((i + 200) * 3));
        for (int i = 0; i < 2000; i++) begin
            int a, b;
            a = int'($urandom_range(32767)) - 16384;
            b = int'($urandom_range(32767)) - 16384;
            if ((i % 97) == 50) tick(0, 0, a, b, '0, 1);
            go(a, b, PWIDTH'(a * b));
        end
        repeat (16) go(0, 0, '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
